// File: rtl/perf_counter_bank_if.sv
// rtl/perf_counter_bank_if.sv - MEM-stage bus view of the performance-counter window
interface perf_counter_bank_if;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [15:0] bus_wdata;
  logic        perf_sel;
  logic [15:0] perf_rdata;

  modport master (
    output bus_addr, bus_rd, bus_wr, bus_wdata,
    input  perf_sel, perf_rdata
  );

  modport slave (
    input  bus_addr, bus_rd, bus_wr, bus_wdata,
    output perf_sel, perf_rdata
  );
endinterface

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - event counters, stall-latency histogram and stall counter behind a register window
module perf_counter_bank #(
  parameter int                          NUM_EVENTS = 4,
  parameter int                          NUM_BINS   = 4,
  parameter int                          CNT_WIDTH  = 16,
  parameter logic [15:0]                 BASE_ADDR  = 16'hFFE0,
  parameter logic [(NUM_BINS-1)*8-1:0]   LAT_THRESH = {8'd5, 8'd3, 8'd0},
  parameter bit                          SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_EVENTS-1:0] event_inc,
  input  logic                  access_active,
  input  logic                  access_stall,
  perf_counter_bank_if.slave    bus
);

  // Counters occupy indices 0..NTOT-1 (events, bins, stall); CTRL sits at NTOT.
  localparam int          NTOT      = NUM_EVENTS + NUM_BINS + 1;
  localparam int          STALL_IDX = NTOT - 1;
  localparam logic [15:0] WIN_LO_W  = BASE_ADDR >> 1;
  localparam logic [15:0] WIN_HI_W  = WIN_LO_W + 16'(NTOT);

  logic [CNT_WIDTH-1:0] cnt_q [NTOT];
  logic [CNT_WIDTH-1:0] cnt_d [NTOT];
  logic                 en_q, en_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           lat_q, lat_d;

  logic [15:0]          word_addr;
  logic [15:0]          idx;
  logic                 in_win;
  logic                 wr_hit;
  logic                 ctrl_wr;
  logic                 clr_all;
  logic                 stall_cyc;
  logic                 complete;
  logic [3:0]           bin_idx;
  logic [NTOT-1:0]      inc_vec;
  logic                 ovf_set;
  logic [15:0]          rdata;

  // Window decode works on word addresses so the byte-select bit drops out.
  always_comb begin
    word_addr = bus.bus_addr >> 1;
    in_win    = (word_addr >= WIN_LO_W) && (word_addr <= WIN_HI_W);
    idx       = word_addr - WIN_LO_W;
    wr_hit    = bus.bus_wr && in_win;
    ctrl_wr   = wr_hit && (idx == 16'(NTOT));
    clr_all   = ctrl_wr && bus.bus_wdata[1];
    stall_cyc = access_active && access_stall;
    complete  = access_active && !access_stall && !bus.perf_sel;
  end

  assign bus.perf_sel   = (bus.bus_rd || bus.bus_wr) && in_win;
  assign bus.perf_rdata = rdata;

  // Read mux returns pre-edge register state, zero when the window is not selected.
  always_comb begin
    rdata = '0;
    if (bus.perf_sel) begin
      if (idx == 16'(NTOT)) begin
        rdata = {ovf_q, 14'd0, en_q};
      end else begin
        for (int k = 0; k < NTOT; k++) begin
          if (idx == 16'(k)) rdata[CNT_WIDTH-1:0] = cnt_q[k];
        end
      end
    end
  end

  // Histogram bin: smallest threshold the finished access fits under, else the last bin.
  always_comb begin
    bin_idx = 4'(NUM_BINS - 1);
    for (int i = NUM_BINS - 2; i >= 0; i--) begin
      if (lat_q <= LAT_THRESH[i*8 +: 8]) bin_idx = 4'(i);
    end
  end

  // Per-counter increment requests, all gated by EN.
  always_comb begin
    inc_vec = '0;
    inc_vec[NUM_EVENTS-1:0] = event_inc;
    for (int b = 0; b < NUM_BINS; b++) begin
      inc_vec[NUM_EVENTS + b] = complete && (bin_idx == 4'(b));
    end
    inc_vec[STALL_IDX] = stall_cyc;
    if (!en_q) inc_vec = '0;
  end

  // Counter next state: clear-all beats a bus write, which beats an increment.
  always_comb begin
    ovf_set = 1'b0;
    for (int k = 0; k < NTOT; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clr_all) begin
        cnt_d[k] = '0;
      end else if (wr_hit && (idx == 16'(k))) begin
        cnt_d[k] = bus.bus_wdata[CNT_WIDTH-1:0];
      end else if (inc_vec[k]) begin
        if (&cnt_q[k]) begin
          ovf_set  = 1'b1;
          cnt_d[k] = SATURATE ? cnt_q[k] : '0;
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // CTRL and latency tracker next state; a new overflow wins over write-1-to-clear.
  always_comb begin
    en_d  = ctrl_wr ? bus.bus_wdata[0] : en_q;
    ovf_d = ovf_q;
    if (ctrl_wr && bus.bus_wdata[15]) ovf_d = 1'b0;
    if (clr_all)                      ovf_d = 1'b0;
    if (ovf_set)                      ovf_d = 1'b1;

    lat_d = lat_q;
    if (clr_all || !en_q) begin
      lat_d = '0;
    end else if (stall_cyc) begin
      lat_d = (lat_q == 8'hFF) ? lat_q : lat_q + 8'd1;
    end else if (complete) begin
      lat_d = '0;
    end
  end

  // State registers; reset also discards any partially measured access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTOT; k++) cnt_q[k] <= '0;
      en_q  <= 1'b1;
      ovf_q <= 1'b0;
      lat_q <= '0;
    end else begin
      for (int k = 0; k < NTOT; k++) cnt_q[k] <= cnt_d[k];
      en_q  <= en_d;
      ovf_q <= ovf_d;
      lat_q <= lat_d;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - directed vectors and corner sequences for perf_counter_bank
module tb_perf_counter_bank;

  localparam logic [15:0] BASE = 16'hFFE0;
  localparam int          CTRL = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] event_inc = '0;
  logic       access_active = 1'b0;
  logic       access_stall = 1'b0;

  int checks = 0;
  int errors = 0;

  perf_counter_bank_if bus_w ();
  perf_counter_bank_if bus_s ();

  perf_counter_bank dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .event_inc     (event_inc),
    .access_active (access_active),
    .access_stall  (access_stall),
    .bus           (bus_w)
  );

  perf_counter_bank #(.SATURATE(1'b1)) dut_s (
    .clk           (clk),
    .rst_n         (rst_n),
    .event_inc     (event_inc),
    .access_active (access_active),
    .access_stall  (access_stall),
    .bus           (bus_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic        exp_sel;
    logic [15:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_bus(input logic [15:0] a, input logic rd, input logic wr, input logic [15:0] d);
    bus_w.bus_addr = a; bus_w.bus_rd = rd; bus_w.bus_wr = wr; bus_w.bus_wdata = d;
    bus_s.bus_addr = a; bus_s.bus_rd = rd; bus_s.bus_wr = wr; bus_s.bus_wdata = d;
  endtask

  function automatic logic [15:0] addr_of(input int k);
    return BASE + 16'(2 * k);
  endfunction

  task automatic rd_chk(input int k, input logic [15:0] exp, input string name);
    @(negedge clk);
    set_bus(addr_of(k), 1'b1, 1'b0, 16'h0);
    #1 chk(name, bus_w.perf_rdata, exp);
    set_bus(16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic rd_chk_s(input int k, input logic [15:0] exp, input string name);
    @(negedge clk);
    set_bus(addr_of(k), 1'b1, 1'b0, 16'h0);
    #1 chk(name, bus_s.perf_rdata, exp);
    set_bus(16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic wr_reg(input int k, input logic [15:0] d, input logic [3:0] ev);
    @(negedge clk);
    set_bus(addr_of(k), 1'b0, 1'b1, d);
    event_inc = ev;
    @(posedge clk);
    #1;
    set_bus(16'h0, 1'b0, 1'b0, 16'h0);
    event_inc = '0;
  endtask

  task automatic pulse_ev(input logic [3:0] ev, input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      event_inc = ev;
    end
    @(negedge clk);
    event_inc = '0;
  endtask

  task automatic access(input int n);
    for (int j = 0; j <= n; j++) begin
      @(negedge clk);
      access_active = 1'b1;
      access_stall  = (j < n);
    end
    @(negedge clk);
    access_active = 1'b0;
    access_stall  = 1'b0;
  endtask

  initial begin
    set_bus(16'h0, 1'b0, 1'b0, 16'h0);

    for (int k = 0; k < CTRL; k++) begin
      vecs.push_back('{addr_of(k), 1'b1, 1'b0, 1'b1, 16'h0000, $sformatf("reset_cnt%0d", k)});
    end
    vecs.push_back('{16'hFFF2, 1'b1, 1'b0, 1'b1, 16'h0001, "reset_ctrl"});
    vecs.push_back('{16'hFFF3, 1'b1, 1'b0, 1'b1, 16'h0001, "ctrl_odd_byte"});
    vecs.push_back('{16'hFFE1, 1'b1, 1'b0, 1'b1, 16'h0000, "cnt0_odd_byte"});
    vecs.push_back('{16'hFFDE, 1'b1, 1'b0, 1'b0, 16'h0000, "below_window"});
    vecs.push_back('{16'hFFDF, 1'b1, 1'b0, 1'b0, 16'h0000, "below_window_odd"});
    vecs.push_back('{16'hFFF4, 1'b1, 1'b0, 1'b0, 16'h0000, "above_window"});
    vecs.push_back('{16'hFFF4, 1'b0, 1'b1, 1'b0, 16'h0000, "above_window_wr"});
    vecs.push_back('{16'hFFF2, 1'b0, 1'b0, 1'b0, 16'h0000, "ctrl_no_strobe"});
    vecs.push_back('{16'h1000, 1'b1, 1'b0, 1'b0, 16'h0000, "far_address"});

    #12 rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      set_bus(vecs[i].addr, vecs[i].rd, vecs[i].wr, 16'h0);
      #1;
      chk({vecs[i].name, "_sel"}, {15'd0, bus_w.perf_sel}, {15'd0, vecs[i].exp_sel});
      chk({vecs[i].name, "_rdata"}, bus_w.perf_rdata, vecs[i].exp_rdata);
      set_bus(16'h0, 1'b0, 1'b0, 16'h0);
    end

    access(0);
    access(2);
    access(7);
    rd_chk(4, 16'd1, "bin0_after_0stall");
    rd_chk(5, 16'd1, "bin1_after_2stall");
    rd_chk(6, 16'd0, "bin2_empty");
    rd_chk(7, 16'd1, "bin3_after_7stall");
    rd_chk(8, 16'd9, "stall_total");

    pulse_ev(4'b1010, 2);
    rd_chk(1, 16'd2, "ev1_count");
    rd_chk(3, 16'd2, "ev3_count");
    rd_chk(0, 16'd0, "ev0_idle");
    rd_chk(2, 16'd0, "ev2_idle");

    wr_reg(1, 16'h0000, 4'b0010);
    rd_chk(1, 16'h0000, "wr_beats_inc_zero");
    wr_reg(3, 16'h0005, 4'b1000);
    rd_chk(3, 16'h0005, "wr_beats_inc_five");

    wr_reg(0, 16'hFFFF, 4'b0000);
    rd_chk(0, 16'hFFFF, "ev0_loaded");
    pulse_ev(4'b0001, 1);
    rd_chk(0, 16'h0000, "wrap_to_zero");
    rd_chk(CTRL, 16'h8001, "wrap_ovf");
    rd_chk_s(0, 16'hFFFF, "sat_sticks");
    rd_chk_s(CTRL, 16'h8001, "sat_ovf");
    wr_reg(CTRL, 16'h8001, 4'b0000);
    rd_chk(CTRL, 16'h0001, "ovf_w1c");
    rd_chk_s(CTRL, 16'h0001, "sat_ovf_w1c");

    wr_reg(0, 16'hFFFF, 4'b0000);
    wr_reg(CTRL, 16'h8001, 4'b0001);
    rd_chk(CTRL, 16'h8001, "ovf_set_beats_clear");
    rd_chk(0, 16'h0000, "wrap_during_w1c");
    rd_chk_s(CTRL, 16'h8001, "sat_set_beats_clear");
    wr_reg(CTRL, 16'h8001, 4'b0000);

    wr_reg(CTRL, 16'h0002, 4'b1111);
    for (int k = 0; k < CTRL; k++) rd_chk(k, 16'h0000, $sformatf("clr_all_cnt%0d", k));
    rd_chk(CTRL, 16'h0000, "clr_all_ctrl");
    pulse_ev(4'b1111, 3);
    access(3);
    rd_chk(0, 16'h0000, "disabled_ev0");
    rd_chk(3, 16'h0000, "disabled_ev3");
    rd_chk(4, 16'h0000, "disabled_bin0");
    rd_chk(8, 16'h0000, "disabled_stall");
    wr_reg(CTRL, 16'h0001, 4'b0000);
    rd_chk(CTRL, 16'h0001, "reenabled");

    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      access_active = 1'b1;
      access_stall  = 1'b1;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    access_stall = 1'b0;
    @(negedge clk);
    access_active = 1'b0;
    rd_chk(4, 16'd1, "rst_mid_stall_bin0");
    rd_chk(6, 16'd0, "rst_mid_stall_bin2");
    rd_chk(8, 16'd0, "rst_mid_stall_total");
    rd_chk(CTRL, 16'h0001, "rst_ctrl");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
